div_unit: RTL



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 33 +++
 rtl/div_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the multi-cycle divider.
//   DIV_WIDTH   - default operand/result width
//   div_state_t - divider control states
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i / quo_i : current partial remainder / quotient
//   div_i         : divisor magnitude
//   rem_o / quo_o : values after shifting {rem,quo} left and a trial subtract
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // One extra bit: with an unsigned divisor near 2^WIDTH the shifted
    // remainder can exceed WIDTH bits before the subtract.
    logic [WIDTH:0] rem_sh;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        if (rem_sh >= {1'b0, div_i}) begin
            // Result is below the divisor, so WIDTH-bit modular math is exact.
            rem_o = rem_sh[WIDTH-1:0] - div_i;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divider (MIPS DIV), quotient -> LO, remainder -> HI.
//   clk, reset (async, active low)
//   DivCtrl      : level start request, held until DivOut/divZero is seen
//   A, B         : dividend / divisor, latched on the accepting edge
//   DivOut       : one-cycle done pulse, HIOut/LOOut valid from that cycle
//   divZero      : one-cycle divide-by-zero pulse (HI/LO left untouched)
//   HIOut, LOOut : remainder / quotient
// Optional build macro DIV_UNSIGNED_EN adds input DivUnsigned (DIVU semantics).
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
`ifdef DIV_UNSIGNED_EN
    input  logic             DivUnsigned,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             DivOut,
    output logic             divZero,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             dout_q, dout_d, dz_q, dz_d;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             uns, a_neg, b_neg;

`ifdef DIV_UNSIGNED_EN
    assign uns = DivUnsigned;
`else
    assign uns = 1'b0;
`endif

    // Unsigned mode clears the sign flags, which disables both abs and sign fix.
    assign a_neg = A[WIDTH-1] & ~uns;
    assign b_neg = B[WIDTH-1] & ~uns;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dout_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (DivCtrl) begin
                    if (B == '0) begin
                        dz_d    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        sa_d    = a_neg;
                        sb_d    = b_neg;
                        // quo holds the dividend magnitude; it shifts out into rem.
                        quo_d   = a_neg ? (0 - A) : A;
                        div_d   = b_neg ? (0 - B) : B;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    // All steps done: sign fix and write-back on this edge.
                    lo_d    = (sa_q ^ sb_q) ? (0 - quo_q) : quo_q;
                    hi_d    = sa_q ? (0 - rem_q) : rem_q;
                    dout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: state_d = DivCtrl ? HOLD : IDLE;
            HOLD: if (!DivCtrl) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dout_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dout_q  <= dout_d;
            dz_q    <= dz_d;
        end
    end

    assign DivOut  = dout_q;
    assign divZero = dz_q;
    assign HIOut   = hi_q;
    assign LOOut   = lo_q;

endmodule
